// File: rtl/xor_frame_parity.sv
// xor_frame_parity: streaming column-wise XOR of a frame with parity, truncation and check-word compare
module xor_frame_parity #(
    parameter int WIDTH     = 8,
    parameter int MAX_BEATS = 16,
    parameter int ODD       = 0,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [WIDTH-1:0]     in_data_i,
    input  logic                 in_valid_i,
    input  logic                 in_last_i,
    output logic                 in_ready_o,
    input  logic                 chk_en_i,
    input  logic [WIDTH-1:0]     chk_word_i,
    output logic [WIDTH-1:0]     out_word_o,
    output logic                 out_parity_o,
    output logic                 out_trunc_o,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic                 err_o,
    output logic [CNT_WIDTH-1:0] err_count_o,
    input  logic                 clr_count_i
);
    localparam int BW = $clog2(MAX_BEATS + 1);

    typedef enum logic {IDLE = 1'b0, ACCUM = 1'b1} state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     acc_q, acc_d, word_q, sum;
    logic [BW-1:0]        cnt_q, cnt_d, beat_num;
    logic                 valid_q, par_q, trunc_q, err_q;
    logic                 accept, term, mism;
    logic [CNT_WIDTH-1:0] ecnt_q;

    // Frame state, running XOR and beat count; reset discards any open frame
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: a terminating beat closes the frame, any other accepted beat keeps it open
    always_comb begin
        state_d = accept ? (term ? IDLE : ACCUM) : state_q;
    end

    // Handshake, beat arithmetic and termination; the first beat of a frame replaces the accumulator
    always_comb begin
        in_ready_o   = ~valid_q | out_ready_i;
        accept       = in_valid_i & in_ready_o;
        sum          = (state_q == IDLE) ? in_data_i : acc_q ^ in_data_i;
        beat_num     = (state_q == IDLE) ? BW'(1) : cnt_q + BW'(1);
        term         = accept & (in_last_i | (beat_num == BW'(MAX_BEATS)));
        mism         = chk_en_i & (sum != chk_word_i);
        acc_d        = accept ? sum : acc_q;
        cnt_d        = accept ? (term ? '0 : beat_num) : cnt_q;
        out_word_o   = word_q;
        out_parity_o = par_q;
        out_trunc_o  = trunc_q;
        out_valid_o  = valid_q;
        err_o        = err_q;
        err_count_o  = ecnt_q;
    end

    // Result holding register: loads on termination, otherwise holds until the consumer takes it
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            word_q  <= '0;
            par_q   <= 1'b0;
            trunc_q <= 1'b0;
            err_q   <= 1'b0;
        end else if (term) begin
            valid_q <= 1'b1;
            word_q  <= sum;
            par_q   <= (^sum) ^ (ODD != 0);
            trunc_q <= ~in_last_i;
            err_q   <= mism;
        end else if (out_ready_i) begin
            valid_q <= 1'b0;
        end
    end

    // Saturating mismatch counter; clear wins over a simultaneous increment
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ecnt_q <= '0;
        end else if (clr_count_i) begin
            ecnt_q <= '0;
        end else if (term && mism && !(&ecnt_q)) begin
            ecnt_q <= ecnt_q + CNT_WIDTH'(1);
        end
    end
endmodule

// File: doc/xor_frame_parity.md
Name: xor_frame_parity

Overview:
- Parametrised successor to the 2-input XOR gate: streaming XOR-reduction engine for WIDTH-bit words.
- Accumulates the column-wise XOR of all beats in a frame and emits the result word plus an overall parity bit.
- Optionally compares the result against a supplied check word and counts mismatches.
- Sits between a valid/ready data source and a consumer as an integrity-check stage.

Parameters:
- WIDTH, 8, data/result word width in bits (>=1).
- MAX_BEATS, 16, maximum beats per frame before forced termination (>=1).
- ODD, 0, parity sense: 0 = even (OUT_PARITY = XOR of OUT_WORD bits), 1 = odd (inverted).
- CNT_WIDTH, 8, width of the saturating error counter.

Ports:
- CLK  input  1  clock, all state on rising edge.
- RST_N  input  1  asynchronous active-low reset.
- IN_DATA  input  WIDTH  input beat.
- IN_VALID  input  1  beat valid.
- IN_LAST  input  1  final beat of frame; qualified by IN_VALID.
- IN_READY  output  1  block can accept a beat.
- CHK_EN  input  1  compare enable; sampled with the last beat.
- CHK_WORD  input  WIDTH  expected result; sampled with the last beat.
- OUT_WORD  output  WIDTH  frame XOR result.
- OUT_PARITY  output  1  parity of OUT_WORD per ODD.
- OUT_TRUNC  output  1  frame was force-terminated at MAX_BEATS.
- OUT_VALID  output  1  result valid.
- OUT_READY  input  1  consumer accepts result.
- ERR  output  1  result mismatched CHK_WORD; valid with OUT_VALID.
- ERR_COUNT  output  CNT_WIDTH  saturating mismatch count.
- CLR_COUNT  input  1  synchronous clear of ERR_COUNT.

Behaviour:
- Reset (RST_N=0, async): acc=0, beat count=0, state IDLE.
- All outputs 0 during and after reset: OUT_WORD, OUT_PARITY, OUT_TRUNC, OUT_VALID, ERR, ERR_COUNT.
- IN_READY=1 after reset.
- States: IDLE (no frame open), ACCUM (>=1 beat accepted, no last yet).
- Output holding register is independent of the state.
- Accept rule: beat accepted when IN_VALID & IN_READY.
- IN_READY = ~OUT_VALID | OUT_READY (combinational). Back-to-back frames run at full rate.
- IDLE + accepted beat: acc <= IN_DATA, count <= 1; go to ACCUM unless the beat terminates the frame.
- ACCUM + accepted beat: acc <= acc ^ IN_DATA, count++.
- Termination: a beat terminates the frame if IN_LAST=1, or if it is beat number MAX_BEATS.
- On termination, the next cycle shows: OUT_VALID=1; OUT_WORD = final acc value including the terminating beat; OUT_PARITY = (^OUT_WORD) ^ ODD.
- OUT_TRUNC=1 only when termination came from MAX_BEATS with IN_LAST=0.
- ERR = CHK_EN & (result != CHK_WORD), using CHK_EN/CHK_WORD sampled on the terminating beat.
- State returns to IDLE on termination.
- Latency: 1 cycle from the terminating beat to OUT_VALID.
- A single-beat frame (IN_LAST on the first beat) gives OUT_WORD=IN_DATA.
- Output handshake: OUT_VALID stays high and all result outputs stay stable until OUT_VALID & OUT_READY.
- If a new frame terminates in the same cycle the old result is accepted, the new result loads with no bubble. Otherwise OUT_VALID drops.
- IN_READY=0 while a result is pending and OUT_READY=0. This stalls input mid-frame with no loss of acc.
- ERR_COUNT increments by 1 in the cycle the result loads with mismatch, and saturates at 2^CNT_WIDTH-1.
- CLR_COUNT=1 sets ERR_COUNT=0 next cycle. It overrides a simultaneous increment.
- Reset mid-frame or with a result pending discards everything. The first post-reset beat starts a fresh frame.
- IN_LAST with IN_VALID=0 is ignored.

Test Plan:
- Reset: RST_N low for 3 cycles, then release -> all outputs 0, IN_READY=1, ERR_COUNT=0.
- Frame 0x0F, 0xF0, 0x3C(last), WIDTH=8, ODD=0, OUT_READY=1 -> one cycle after the last beat OUT_VALID=1, OUT_WORD=0xC3, OUT_PARITY=0, OUT_TRUNC=0. With ODD=1 -> OUT_PARITY=1.
- Same frame with CHK_EN=1:
  - CHK_WORD=0xC2 -> ERR=1, ERR_COUNT 0->1.
  - CHK_WORD=0xC3 -> ERR=0, count unchanged.
  - CLR_COUNT pulsed with a mismatch in the same cycle -> ERR_COUNT=0.
- Backpressure: OUT_READY=0 after a result; send 0xAA, 0x55(last) -> OUT_WORD held at the first result and IN_READY=0. Raise OUT_READY -> first result accepted, then 0xAA, 0x55 accepted on consecutive cycles, OUT_WORD=0xFF.
- Truncation with MAX_BEATS=4: beats 0x01, 0x02, 0x04, 0x08, 0x10, all IN_LAST=0 -> after the 4th beat OUT_WORD=0x0F and OUT_TRUNC=1. The 5th beat opens a new frame; its later LAST with 0x10 alone -> OUT_WORD=0x10.
- Reset mid-frame after beats 0xFF, 0x0F: pulse RST_N low, then send single-beat frame 0x33(last) -> OUT_WORD=0x33, ERR_COUNT=0. Saturation check with CNT_WIDTH=2: 5 mismatches -> ERR_COUNT stops at 3.
